// File: rtl/corral_pkg.sv
// Shared types and default timing for the Corral input path and game controller.
package corral_pkg;
  typedef logic [2:0] move_t;

  localparam move_t MOVE_NONE           = 3'b000;
  localparam int    DEF_SYNC_STAGES     = 2;
  localparam int    DEF_DEBOUNCE_CYCLES = 4;
  localparam int    DEF_REPEAT_CYCLES   = 16;
endpackage

// File: rtl/corral_debounce.sv
// Synchronizer chain plus debounce counter for one raw bit.
// The output rise is a registered one-cycle pulse when q_level goes 0->1.
module corral_debounce
  import corral_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic d_raw,
  output logic q_level,
  output logic rise
);
  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   d_s;

  assign sync_d[0] = d_raw;
  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
    assign sync_d[gi] = sync_q[gi-1];
  end
  assign d_s = sync_q[SYNC_STAGES-1];

  // The level flips only after the counter has sat at its maximum with the
  // input still disagreeing, so any agreement in between restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (d_s != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = d_s;
        rise_d  = d_s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign q_level = level_q;
  assign rise    = rise_q;
endmodule

// File: rtl/corral_input_conditioner.sv
// Pad front end: sync/debounce enter, sync move, hand out one move command per press.
// Define CORRAL_AUTOREPEAT_EN to generate repeat presses while enter is held.
module corral_input_conditioner
  import corral_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enter_raw,
  input  logic [2:0] move_raw,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output move_t      cmd_move,
  output logic       enter_level,
  output logic       dropped
);
  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("corral_input_conditioner: illegal parameter value");
  end

  localparam int            WIN     = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
  localparam int            WW      = $clog2(WIN + 1);
  localparam logic [WW-1:0] WIN_END = WW'(WIN);

  logic    level_w, rise_w, rep_press, press, xfer;
  move_t   move_sync_q [SYNC_STAGES];
  move_t   move_sync_d [SYNC_STAGES];
  move_t   move_s;
  logic [WW-1:0] win_q, win_d;
  logic    block_q, block_d;
  logic    cmd_valid_q, cmd_valid_d;
  move_t   cmd_move_q, cmd_move_d;
  logic    dropped_q, dropped_d;

  corral_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_enter (
    .clock  (clock),
    .reset  (reset),
    .d_raw  (enter_raw),
    .q_level(level_w),
    .rise   (rise_w)
  );

  assign move_sync_d[0] = move_raw;
  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_move_sync
    assign move_sync_d[gi] = move_sync_q[gi-1];
  end
  assign move_s = move_sync_q[SYNC_STAGES-1];

`ifdef CORRAL_AUTOREPEAT_EN
  localparam int            RW      = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_END = RW'(REPEAT_CYCLES);

  logic [RW-1:0] rep_q, rep_d;

  // Counts cycles since the last (real or synthetic) press while held.
  always_comb begin
    rep_d = '0;
    if (level_w) begin
      rep_d = (rise_w || rep_q == REP_END) ? RW'(1) : rep_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) rep_q <= '0;
    else       rep_q <= rep_d;
  end

  assign rep_press = level_w && (rep_q == REP_END);
`else
  assign rep_press = 1'b0;
`endif

  // A press held through reset must not turn into a command: the block stays
  // set until the debounced level is seen low after the pipeline has flushed.
  always_comb begin
    win_d   = (win_q == WIN_END) ? win_q : win_q + 1'b1;
    block_d = block_q && !((win_q == WIN_END) && !level_w);
  end

  always_comb begin
    press       = (rise_w || rep_press) && !block_q;
    xfer        = cmd_valid_q && cmd_ready;
    cmd_valid_d = cmd_valid_q && !xfer;
    cmd_move_d  = cmd_move_q;
    dropped_d   = 1'b0;
    if (press) begin
      if (!cmd_valid_q || xfer) begin
        cmd_valid_d = 1'b1;
        cmd_move_d  = move_s;
      end else begin
        dropped_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) move_sync_q[i] <= MOVE_NONE;
      win_q       <= '0;
      // Raw sample taken only while reset is held; metastability here just
      // decides whether one boundary press is suppressed.
      block_q     <= enter_raw;
      cmd_valid_q <= 1'b0;
      cmd_move_q  <= MOVE_NONE;
      dropped_q   <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) move_sync_q[i] <= move_sync_d[i];
      win_q       <= win_d;
      block_q     <= block_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_move_q  <= cmd_move_d;
      dropped_q   <= dropped_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_move    = cmd_move_q;
  assign enter_level = level_w;
  assign dropped     = dropped_q;
endmodule

// File: tb/tb_corral_input_conditioner.sv
// Directed bench for corral_input_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16).
module tb_corral_input_conditioner;
  import corral_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enter_raw = 1'b0;
  logic [2:0] move_raw = 3'b000;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  move_t      cmd_move;
  logic       enter_level;
  logic       dropped;

  int checks = 0;
  int errors = 0;

  corral_input_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES  (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enter_raw  (enter_raw),
    .move_raw   (move_raw),
    .cmd_ready  (cmd_ready),
    .cmd_valid  (cmd_valid),
    .cmd_move   (cmd_move),
    .enter_level(enter_level),
    .dropped    (dropped)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] mv;
    logic       rdy;
    int         n;
    logic       ev;
    logic [2:0] em;
    logic       el;
    logic       ed;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic add(input logic rst, input logic en, input logic [2:0] mv, input logic rdy,
                     input int n, input logic ev, input logic [2:0] em, input logic el,
                     input logic ed);
    vec_t v;
    v.rst = rst; v.en = en; v.mv = mv; v.rdy = rdy; v.n = n;
    v.ev = ev; v.em = em; v.el = el; v.ed = ed;
    tbl.push_back(v);
  endtask

  initial begin
    bit autorep;
    int t;
    logic exp_v;
`ifdef CORRAL_AUTOREPEAT_EN
    autorep = 1'b1;
`else
    autorep = 1'b0;
`endif

    //   rst en mv      rdy n  ev em      el ed
    add(1, 0, 3'b000, 0, 2, 0, 3'b000, 0, 0);  // reset state
    add(0, 1, 3'b101, 0, 6, 0, 3'b000, 0, 0);  // edges 0..5: still debouncing
    add(0, 1, 3'b101, 0, 1, 0, 3'b000, 1, 0);  // edge 6: level rises
    add(0, 1, 3'b101, 0, 1, 1, 3'b101, 1, 0);  // edge 7: command appears
    add(0, 1, 3'b101, 0, 4, 1, 3'b101, 1, 0);  // held without ready
    add(0, 0, 3'b101, 0, 7, 1, 3'b101, 0, 0);  // release: no command, level falls
    add(0, 1, 3'b010, 0, 6, 1, 3'b101, 0, 0);  // second press debouncing
    add(0, 1, 3'b010, 0, 1, 1, 3'b101, 1, 0);
    add(0, 1, 3'b010, 0, 1, 1, 3'b101, 1, 1);  // dropped pulse, move kept
    add(0, 1, 3'b010, 0, 1, 1, 3'b101, 1, 0);
    add(0, 1, 3'b010, 1, 1, 0, 3'b000, 1, 0);  // accepted
    add(0, 1, 3'b010, 0, 1, 0, 3'b000, 1, 0);
    add(0, 0, 3'b010, 0, 7, 0, 3'b000, 0, 0);
    add(0, 1, 3'b011, 0, 8, 1, 3'b011, 1, 0);  // new command 011
    add(0, 0, 3'b011, 0, 7, 1, 3'b011, 0, 0);
    add(0, 1, 3'b110, 0, 7, 1, 3'b011, 1, 0);  // press pending
    add(0, 1, 3'b110, 1, 1, 1, 3'b110, 1, 0);  // transfer + load same cycle
    add(0, 1, 3'b110, 0, 1, 1, 3'b110, 1, 0);
    add(0, 1, 3'b110, 1, 1, 0, 3'b000, 1, 0);
    add(0, 0, 3'b110, 0, 7, 0, 3'b000, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      reset     = tbl[i].rst;
      enter_raw = tbl[i].en;
      move_raw  = tbl[i].mv;
      cmd_ready = tbl[i].rdy;
      repeat (tbl[i].n) tick();
      chk($sformatf("row%0d cmd_valid", i), 32'(cmd_valid), 32'(tbl[i].ev));
      chk($sformatf("row%0d enter_level", i), 32'(enter_level), 32'(tbl[i].el));
      chk($sformatf("row%0d dropped", i), 32'(dropped), 32'(tbl[i].ed));
      if (tbl[i].ev) chk($sformatf("row%0d cmd_move", i), 32'(cmd_move), 32'(tbl[i].em));
      $display("row %0d: valid=%0b move=%03b level=%0b dropped=%0b", i, cmd_valid, cmd_move,
               enter_level, dropped);
    end

    // Short glitch never changes the debounced level.
    enter_raw = 1'b1;
    repeat (3) tick();
    enter_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("glitch%0d level", i), 32'(enter_level), 32'd0);
      chk($sformatf("glitch%0d valid", i), 32'(cmd_valid), 32'd0);
    end
    $display("glitch: level=%0b valid=%0b", enter_level, cmd_valid);

    // Reset while a command is held and enter stays pressed.
    enter_raw = 1'b1; move_raw = 3'b111; cmd_ready = 1'b0;
    repeat (8) tick();
    chk("rst_pre valid", 32'(cmd_valid), 32'd1);
    chk("rst_pre move", 32'(cmd_move), 32'h7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst valid", 32'(cmd_valid), 32'd0);
    chk("rst move", 32'(cmd_move), 32'h0);
    chk("rst level", 32'(enter_level), 32'd0);
    chk("rst dropped", 32'(dropped), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("held%0d valid", i), 32'(cmd_valid), 32'd0);
    end
    chk("held level", 32'(enter_level), 32'd1);
    enter_raw = 1'b0;
    repeat (8) tick();
    chk("rel level", 32'(enter_level), 32'd0);
    chk("rel valid", 32'(cmd_valid), 32'd0);
    enter_raw = 1'b1; move_raw = 3'b001;
    repeat (8) tick();
    chk("fresh valid", 32'(cmd_valid), 32'd1);
    chk("fresh move", 32'(cmd_move), 32'h1);
    $display("reset seq: valid=%0b move=%03b", cmd_valid, cmd_move);

    // Held enter with ready high: auto-repeat only when the macro is defined.
    enter_raw = 1'b0; cmd_ready = 1'b1;
    repeat (8) tick();
    chk("ar_pre valid", 32'(cmd_valid), 32'd0);
    enter_raw = 1'b1; move_raw = 3'b100;
    for (t = 1; t <= 48; t++) begin
      tick();
      exp_v = (t == 8) || (autorep && (t == 24 || t == 40));
      chk($sformatf("ar t%0d valid", t), 32'(cmd_valid), 32'(exp_v));
      if (exp_v) begin
        chk($sformatf("ar t%0d move", t), 32'(cmd_move), 32'h4);
        $display("autorepeat: command at t=%0d move=%03b", t, cmd_move);
      end
    end
    enter_raw = 1'b0; cmd_ready = 1'b0;
    repeat (8) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
